// File: rtl/radix4_pkg.sv
// -----------------------------------------------------------------------------
// radix4_pkg
// Shared definitions for the Radix4 signed multiplier sequencer:
//   - operand / product widths
//   - default load and compute window lengths
//   - sequencer state encoding
//   - small constant helper used to size the window counter
// -----------------------------------------------------------------------------
package radix4_pkg;

  localparam int OP_W               = 32;
  localparam int PROD_W             = 64;
  localparam int LOAD_CYCLES_DEF    = 3;
  localparam int COMPUTE_CYCLES_DEF = 40;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    HOLD    = 2'd3
  } seq_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/radix4_mult_sequencer.sv
// -----------------------------------------------------------------------------
// radix4_mult_sequencer
// Valid/ready front and back end for the sequential Radix4 signed 32x32
// multiplier. An accepted operand pair is held on mult_m/mult_q, the
// multiplier is kept in reset for LOAD_CYCLES, released for COMPUTE_CYCLES,
// and its output is captured into res_data, which is then offered on the
// result port until consumed. No arithmetic happens here.
//
// Optional build macro: MULT_SEQ_STATS_EN adds op_count / stall_cycles.
//
// Ports:
//   clk          in   clock, all logic on rising edge
//   reset        in   synchronous active-high reset
//   in_valid     in   operand pair present
//   in_ready     out  sequencer can accept a pair (IDLE)
//   in_m, in_q   in   32-bit two's-complement operands
//   res_valid    out  product available (HOLD)
//   res_ready    in   consumer takes product
//   res_data     out  64-bit product, bit-exact copy of mult_out
//   busy         out  high in LOAD, COMPUTE and HOLD
//   mult_m/q     out  operands to the multiplier
//   mult_rst     out  multiplier reset (low only during COMPUTE)
//   mult_out     in   multiplier product
//   op_count     out  (stats build) completed result transfers, wraps
//   stall_cycles out  (stats build) HOLD cycles with res_ready low, saturates
// -----------------------------------------------------------------------------
module radix4_mult_sequencer
  import radix4_pkg::*;
#(
  parameter int LOAD_CYCLES    = LOAD_CYCLES_DEF,
  parameter int COMPUTE_CYCLES = COMPUTE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_m,
  input  logic [OP_W-1:0]   in_q,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PROD_W-1:0] res_data,
  output logic              busy,
  output logic [OP_W-1:0]   mult_m,
  output logic [OP_W-1:0]   mult_q,
  output logic              mult_rst,
  input  logic [PROD_W-1:0] mult_out
`ifdef MULT_SEQ_STATS_EN
  ,
  output logic [15:0]       op_count,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int CNT_W = $clog2(max_int(LOAD_CYCLES, COMPUTE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] LOAD_INIT    = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] COMPUTE_INIT = CNT_W'(COMPUTE_CYCLES - 1);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0]    op_m_q, op_q_q;
  logic [PROD_W-1:0]  res_data_q;
  logic               accept;
  logic               capture;

  // Next-state, window counter and decoded outputs. All outputs decode the
  // registered state only, so they change on clock edges.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    capture   = 1'b0;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    mult_rst  = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = LOAD;
          cnt_d   = LOAD_INIT;
        end
      end
      LOAD: begin
        if (cnt_q == '0) begin
          state_d = COMPUTE;
          cnt_d   = COMPUTE_INIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      COMPUTE: begin
        mult_rst = 1'b0;
        if (cnt_q == '0) begin
          // Last compute cycle: mult_out is final, grab it on this edge.
          capture = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_m_q     <= '0;
      op_q_q     <= '0;
      res_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_m_q <= in_m;
        op_q_q <= in_q;
      end
      if (capture) begin
        res_data_q <= mult_out;
      end
    end
  end

  assign mult_m   = op_m_q;
  assign mult_q   = op_q_q;
  assign res_data = res_data_q;

`ifdef MULT_SEQ_STATS_EN
  logic [15:0] op_count_q;
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_count_q <= '0;
      stall_q    <= '0;
    end else if (state_q == HOLD) begin
      if (res_ready) begin
        op_count_q <= op_count_q + 16'd1;
      end else if (stall_q != 16'hFFFF) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  assign op_count     = op_count_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_radix4_mult_sequencer.sv
// -----------------------------------------------------------------------------
// tb_radix4_mult_sequencer
// Scoreboard bench for radix4_mult_sequencer. The driver pushes the expected
// product and accept edge when a pair is accepted; a monitor pops and checks
// data and latency whenever the DUT presents a result. The Radix4 multiplier
// is represented by a behavioural stand-in that only presents the final
// product once mult_rst has been low for COMPUTE_CYCLES-1 edges (before that
// it shows the inverted product), so early or late capture is visible.
// -----------------------------------------------------------------------------
module tb_radix4_mult_sequencer;

  localparam int LOAD_CYCLES    = 3;
  localparam int COMPUTE_CYCLES = 40;
  localparam int LATENCY        = LOAD_CYCLES + COMPUTE_CYCLES;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_m;
  logic [31:0] in_q;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic        busy;
  logic [31:0] mult_m;
  logic [31:0] mult_q;
  logic        mult_rst;
  logic [63:0] mult_out;
`ifdef MULT_SEQ_STATS_EN
  logic [15:0] op_count;
  logic [15:0] stall_cycles;
`endif

  radix4_mult_sequencer #(
    .LOAD_CYCLES    (LOAD_CYCLES),
    .COMPUTE_CYCLES (COMPUTE_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_m         (in_m),
    .in_q         (in_q),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .busy         (busy),
    .mult_m       (mult_m),
    .mult_q       (mult_q),
    .mult_rst     (mult_rst),
    .mult_out     (mult_out)
`ifdef MULT_SEQ_STATS_EN
    ,
    .op_count     (op_count),
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier stand-in.
  int                 mk = 0;
  logic signed [63:0] model_prod;
  assign model_prod = $signed({{32{mult_m[31]}}, mult_m}) * $signed({{32{mult_q[31]}}, mult_q});
  always @(posedge clk) begin
    if (mult_rst) mk <= 0;
    else if (mk < 1000) mk <= mk + 1;
  end
  assign mult_out = (mk >= COMPUTE_CYCLES - 1) ? model_prod : ~model_prod;

  typedef struct {
    logic [63:0] data;
    int          acc_edge;
  } sb_entry_t;

  sb_entry_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, where inputs for the next rising
  // edge are already stable.
  logic rv_prev = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      rv_prev = 1'b0;
    end else begin
      if (res_valid && !rv_prev) begin
        if (sb.size() == 0) fail("unexpected_res_valid");
        else check("latency", 64'(cyc - sb[0].acc_edge), 64'(LATENCY));
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          fail("unexpected_transfer");
        end else begin
          sb_entry_t e;
          e = sb.pop_front();
          check("res_data", res_data, e.data);
        end
      end
      rv_prev = res_valid;
    end
  end

  // Wait for in_ready, present the pair for one edge, then scramble the
  // operand inputs so any late latching is visible.
  task automatic issue(input logic [31:0] m, input logic [31:0] q,
                       input logic [63:0] exp, input bit track, output int acc);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) fail("issue_timeout");
    in_valid = 1'b1;
    in_m     = m;
    in_q     = q;
    tick();
    in_valid = 1'b0;
    in_m     = ~m;
    in_q     = ~q;
    acc      = cyc;
    if (track) sb.push_back('{data: exp, acc_edge: acc});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    if (sb.size() != 0) fail("drain_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic signed [63:0] ref_last;
  int acc0, acc1, acc2, dummy;
  int n;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_m      = 32'h0;
    in_q      = 32'h0;
    res_ready = 1'b1;
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", res_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mult_rst", 64'(mult_rst), 64'd1);
    check("rst_mult_m", 64'(mult_m), 64'd0);
    check("rst_mult_q", 64'(mult_q), 64'd0);
    reset = 1'b0;
    tick();

    // Single operations with the result port always ready.
    issue(32'h00087234, 32'h00000348, 64'h000000001BB6BAA0, 1'b1, dummy);
    check("busy_after_accept", 64'(busy), 64'd1);
    check("mult_m_latched", 64'(mult_m), 64'h00087234);
    wait_drain();
    issue(32'hFFFFFEFD, 32'hFFFFFEFD, 64'h0000000000010609, 1'b1, dummy);
    wait_drain();
    issue(32'hB887CAAF, 32'h00000001, 64'hFFFFFFFFB887CAAF, 1'b1, dummy);
    wait_drain();

    // Backpressure: hold res_ready low for 10 cycles in HOLD while a new
    // pair is offered on the input.
    res_ready = 1'b0;
    issue(32'h00000007, 32'h00000003, 64'h0000000000000015, 1'b1, dummy);
    n = 0;
    while (!res_valid && n < 100) begin
      tick();
      n++;
    end
    if (!res_valid) fail("bp_res_valid_timeout");
    in_valid = 1'b1;
    in_m     = 32'h12345678;
    in_q     = 32'h9ABCDEF0;
    for (int i = 0; i < 10; i++) begin
      check("bp_res_valid", 64'(res_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_res_data", res_data, 64'h15);
      check("bp_mult_m", 64'(mult_m), 64'h7);
      tick();
    end
    in_valid = 1'b0;
`ifdef MULT_SEQ_STATS_EN
    check("stall_cycles", 64'(stall_cycles), 64'd10);
`endif
    res_ready = 1'b1;
    tick();
    check("bp_in_ready_after", 64'(in_ready), 64'd1);
    check("bp_res_valid_after", 64'(res_valid), 64'd0);
    check("bp_mult_q_not_latched", 64'(mult_q), 64'h3);
`ifdef MULT_SEQ_STATS_EN
    check("op_count", 64'(op_count), 64'd4);
`endif
    wait_drain();

    // Back-to-back with res_ready tied high: one product every 45 cycles.
    issue(32'h50647236, 32'h50612336, 64'h193DE4CED7437964, 1'b1, acc0);
    in_valid = 1'b0;
    issue(32'h00000000, 32'h50647236, 64'h0000000000000000, 1'b1, acc1);
    issue(32'h00000001, 32'h50647236, 64'h0000000050647236, 1'b1, acc2);
    check("b2b_spacing_1", 64'(acc1 - acc0), 64'(LATENCY + 2));
    check("b2b_spacing_2", 64'(acc2 - acc1), 64'(LATENCY + 2));
    wait_drain();

    // Reset in the middle of COMPUTE discards the operation.
    issue(32'h00000011, 32'h00000022, 64'h0, 1'b0, dummy);
    for (int i = 0; i < 20; i++) tick();
    check("mid_mult_rst_low", 64'(mult_rst), 64'd0);
    reset = 1'b1;
    tick();
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_res_valid", 64'(res_valid), 64'd0);
    check("mid_rst_mult_rst", 64'(mult_rst), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    tick();
    // Reference product computed in the bench for this pair.
    ref_last = $signed({{32{1'b1}}, 32'hB887CAAF}) * $signed({32'h0, 32'h50647236});
    issue(32'hB887CAAF, 32'h50647236, ref_last, 1'b1, dummy);
    wait_drain();
    for (int i = 0; i < 5; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
